rr_arbiter_32: RTL and testbench
================================

Name: rr_arbiter_32

Overview:
- Round-robin arbiter that shares one 32-way resource select among 32 requesters.
- Registers the winning 5-bit index and holds it for the grant tenure.
- Drives a one-hot 32-bit grant through the team's existing 5-to-32 decoder (Lab2_decoder_5x32), with the decoder enable tied to grant-active.
- Sits between the requesters and the shared datapath select, replacing static decoder drive in Lab 3.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles per tenure before forced release; legal range 1..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- req  input  32  request vector; bit i is requester i, level-sensitive.
- grant  output  32  one-hot grant; all zeros when no grant is active.
- grant_valid  output  1  high while a grant is active (state GRANT).
- grant_idx  output  5  index of the current or last granted requester.
- preempt  output  1  one-cycle pulse, in the cycle a tenure ends by MAX_HOLD expiry while req[grant_idx] is still high.

Behaviour:
- Reset, on a clk edge with rst=1:
  - state=IDLE, ptr=0, grant_idx=0, hold_cnt=0, preempt=0.
  - grant=0 and grant_valid=0.
  - Applies mid-tenure too: grant drops at that edge, and no preempt pulse is generated.
- grant = decoder(grant_idx, enable = (state==GRANT)).
  - Combinational from registers only; there is no combinational path from req to any output.
- State IDLE:
  - If req != 0: the winner is the first set bit searching circularly from ptr upward (ptr, ptr+1, ..., 31, 0, ..., ptr-1).
  - On the winning edge: grant_idx <= winner, hold_cnt <= 0, state <= GRANT.
  - Latency: a req sampled at edge k gives grant visible after edge k (one cycle).
  - If req == 0: remain in IDLE; grant_idx keeps its old value.
- State GRANT, release conditions evaluated each edge:
  - a) req[grant_idx] == 0 -> normal release.
  - b) hold_cnt == MAX_HOLD-1 and req[grant_idx] == 1 -> forced release; preempt=1 for the following cycle.
  - If both a) and b) are true, it is a normal release; no preempt.
  - On release: ptr <= grant_idx+1 (mod 32; 31 wraps to 0), state <= IDLE.
  - Otherwise: hold_cnt <= hold_cnt+1 and stay in GRANT.
- Handover:
  - Every release is followed by exactly one dead cycle (IDLE, grant=0) before the next grant. Throughput is therefore at most MAX_HOLD grant cycles per MAX_HOLD+1 cycles.
  - A requester that is force-released has lowest priority at the next arbitration.
  - If it is the only requester, it is re-granted after the dead cycle.
- Other requesters' bits changing during a tenure have no effect until the next IDLE evaluation.
- MAX_HOLD=1: every tenure is exactly one cycle; preempt fires whenever that requester still asserts req.
- All 32 bits asserted continuously: grants rotate 0,1,...,31,0 with no starvation. Worst-case wait is 31*(MAX_HOLD+1) cycles.

Decomposition:
- Shared package (lab3_arb_pkg):
  - State encoding constants: IDLE=1'b0, GRANT=1'b1.
  - N_REQ=32 and IDX_W=5.
  - The circular first-set-bit search as a function, find_next(req, ptr) -> 5-bit index.
- Sub-module: one instance of Lab2_decoder_5x32 (Dout=grant, A=grant_idx, enable=grant_valid). No other sub-modules.
- Expected size: about 150 lines.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 for 10 cycles -> grant=0, grant_valid=0, grant_idx=0, preempt=0 throughout.
- Single short request: req=32'h0000_0010 for 3 cycles, then 0 -> grant=32'h10 one cycle after req, lasting 3 cycles; grant_idx=4; ptr becomes 5; one dead cycle; no preempt.
- Round-robin wrap: req=32'h8000_0001 held, MAX_HOLD=8 -> grant_idx sequence 0,31,0,31.
  - Each tenure lasts 8 cycles, followed by 1 dead cycle.
  - preempt pulses after each tenure.
  - ptr wraps 31->0.
- Simultaneous expiry and drop: a single requester idx 7 holds req for exactly MAX_HOLD cycles and drops it on the expiry edge -> normal release, preempt=0.
- Lone forced requester: only req[3] held high, MAX_HOLD=2 -> pattern grant=32'h8, 32'h8, 0, 32'h8, 32'h8, 0 ...; preempt high in each dead cycle.
- Reset mid-tenure: grant active on idx 12, assert rst for 1 cycle -> grant=0 at that edge; ptr=0.
  - With req=32'h0000_1001 after reset, the next grant is idx 0, not 12.

Source files
------------

// File: rtl/lab3_arb_pkg.sv
// Shared types and helpers for the 32-way round-robin arbiter.
package lab3_arb_pkg;

  localparam int N_REQ = 32;
  localparam int IDX_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // First set bit searching circularly upward from ptr; returns ptr when req is empty.
  function automatic logic [IDX_W-1:0] find_next(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    logic             found;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/Lab2_decoder_5x32.sv
// 5-to-32 one-hot decoder with enable; all outputs low when disabled.
module Lab2_decoder_5x32 (
  output logic [31:0] Dout,
  input  logic [4:0]  A,
  input  logic        enable
);

  always_comb begin
    Dout = '0;
    if (enable) Dout[A] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_32.sv
// Round-robin arbiter for 32 requesters with bounded tenure and one dead cycle per handover.
//
//   state | meaning
//   IDLE  | no grant; arbitrate from ptr when any req is set
//   GRANT | grant_idx owns the resource until it drops req or hits MAX_HOLD
module rr_arbiter_32
  import lab3_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             preempt
);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      hold_cnt  <= '0;
      preempt   <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant_idx <= find_next(req, ptr);
            hold_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // A drop on the expiry edge counts as a normal release, so check req first.
          if (!req[grant_idx]) begin
            ptr   <= grant_idx + IDX_W'(1);
            state <= IDLE;
          end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
            ptr     <= grant_idx + IDX_W'(1);
            state   <= IDLE;
            preempt <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_valid = (state == GRANT);

  Lab2_decoder_5x32 u_dec (
    .Dout   (grant),
    .A      (grant_idx),
    .enable (grant_valid)
  );

endmodule

// File: tb/tb_rr_arbiter_32.sv
// Directed bench for rr_arbiter_32: one instance at MAX_HOLD=8, one at MAX_HOLD=2.
module tb_rr_arbiter_32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req, req2;
  logic [31:0] grant, grant2;
  logic        grant_valid, grant_valid2;
  logic [4:0]  grant_idx, grant_idx2;
  logic        preempt, preempt2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rr_arbiter_32 #(.MAX_HOLD(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .preempt(preempt)
  );

  rr_arbiter_32 #(.MAX_HOLD(2), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .grant(grant2),
    .grant_valid(grant_valid2), .grant_idx(grant_idx2), .preempt(preempt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [31:0] g, input logic v,
                      input logic [4:0] idx, input logic p);
    chk({tag, ".grant"},   grant,               g);
    chk({tag, ".valid"},   {31'd0, grant_valid}, {31'd0, v});
    chk({tag, ".idx"},     {27'd0, grant_idx},  {27'd0, idx});
    chk({tag, ".preempt"}, {31'd0, preempt},    {31'd0, p});
  endtask

  task automatic chk2(input string tag, input logic [31:0] g, input logic v,
                      input logic [4:0] idx, input logic p);
    chk({tag, ".grant"},   grant2,               g);
    chk({tag, ".valid"},   {31'd0, grant_valid2}, {31'd0, v});
    chk({tag, ".idx"},     {27'd0, grant_idx2},  {27'd0, idx});
    chk({tag, ".preempt"}, {31'd0, preempt2},    {31'd0, p});
  endtask

  initial begin
    logic [4:0] exp_idx;

    // Reset then idle
    rst  = 1'b1;
    req  = '0;
    req2 = '0;
    tick();
    tick();
    chk8("rst", 32'h0, 1'b0, 5'd0, 1'b0);
    chk2("rst2", 32'h0, 1'b0, 5'd0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk8("idle", 32'h0, 1'b0, 5'd0, 1'b0);
    end

    // Single short request on idx 4 for three cycles
    req = 32'h0000_0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk8("short", 32'h10, 1'b1, 5'd4, 1'b0);
    end
    req = '0;
    tick();
    chk8("short_dead", 32'h0, 1'b0, 5'd4, 1'b0);

    // ptr should now be 5: with bits 0 and 5 set, idx 5 wins
    req = 32'h0000_0021;
    tick();
    chk8("ptr5", 32'h20, 1'b1, 5'd5, 1'b0);
    req = '0;
    tick();
    chk8("ptr5_rel", 32'h0, 1'b0, 5'd5, 1'b0);

    // Round-robin wrap between 0 and 31, fresh from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 32'h8000_0001;
    for (int t = 0; t < 4; t++) begin
      exp_idx = (t % 2 == 0) ? 5'd0 : 5'd31;
      for (int c = 0; c < 8; c++) begin
        tick();
        chk8("wrap_grant", 32'h1 << exp_idx, 1'b1, exp_idx, 1'b0);
      end
      tick();
      chk8("wrap_dead", 32'h0, 1'b0, exp_idx, 1'b1);
    end
    req = '0;
    tick();
    chk8("wrap_idle", 32'h0, 1'b0, 5'd31, 1'b0);

    // idx 7 drops req on the same edge the hold limit is reached
    req = 32'h0000_0080;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk8("expiry_grant", 32'h80, 1'b1, 5'd7, 1'b0);
    end
    req = '0;
    tick();
    chk8("expiry_drop", 32'h0, 1'b0, 5'd7, 1'b0);

    // Lone requester 3 on the MAX_HOLD=2 instance
    req2 = 32'h0000_0008;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk2("lone_g0", 32'h8, 1'b1, 5'd3, 1'b0);
      tick();
      chk2("lone_g1", 32'h8, 1'b1, 5'd3, 1'b0);
      tick();
      chk2("lone_dead", 32'h0, 1'b0, 5'd3, 1'b1);
    end
    req2 = '0;
    tick();
    chk2("lone_idle", 32'h0, 1'b0, 5'd3, 1'b0);

    // Reset in the middle of a tenure on idx 12 (ptr is 8 here)
    req = 32'h0000_1000;
    tick();
    chk8("mid_grant", 32'h1000, 1'b1, 5'd12, 1'b0);
    tick();
    chk8("mid_hold", 32'h1000, 1'b1, 5'd12, 1'b0);
    rst = 1'b1;
    tick();
    chk8("mid_rst", 32'h0, 1'b0, 5'd0, 1'b0);
    rst = 1'b0;
    req = 32'h0000_1001;
    tick();
    chk8("post_rst", 32'h1, 1'b1, 5'd0, 1'b0);
    req = '0;
    tick();
    chk8("post_rst_rel", 32'h0, 1'b0, 5'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
